// File: rtl/frame_gen_pam4_if.sv
// Handshake/bus bundle between transmit control and the framed pattern source.
// master = controller side, slave = generator side.
interface frame_gen_pam4_if #(
    parameter int NCH   = 3,
    parameter int SYM_W = 2
);
    logic                 start;
    logic                 continuous;
    logic                 stop;
    logic [NCH*SYM_W-1:0] data_out;
    logic                 valid;
    logic                 frame_start;
    logic                 frame_end;
    logic                 busy;
    logic [15:0]          frame_cnt;

    modport master (
        output start, continuous, stop,
        input  data_out, valid, frame_start, frame_end, busy, frame_cnt
    );
    modport slave (
        input  start, continuous, stop,
        output data_out, valid, frame_start, frame_end, busy, frame_cnt
    );
endinterface

// File: rtl/frame_gen_pam4.sv
// Framed multi-channel test-pattern source: header / PRBS payload / idle gap,
// one SYM_W-bit symbol per channel per clock, with per-channel LFSR seeds.
module frame_gen_pam4_lane #(
    parameter int         N     = 7,
    parameter int         T     = 6,
    parameter int         SYM_W = 2,
    parameter bit         INV   = 1'b0,
    parameter logic [N:1] SEED  = '1
) (
    input  logic             clk,
    input  logic             load,
    input  logic             adv,
    output logic [SYM_W-1:0] sym
);
    logic [N:1] s, s_nxt;
    logic       f;

    // SYM_W LFSR steps per symbol; first generated bit lands in the MSB.
    always_comb begin
        s_nxt = s;
        sym   = '0;
        f     = 1'b0;
        for (int i = SYM_W-1; i >= 0; i--) begin
            f      = s_nxt[N] ^ s_nxt[T];
            s_nxt  = {s_nxt[N-1:1], f};
            sym[i] = f ^ INV;
        end
    end

    always_ff @(posedge clk) begin
        if (load)     s <= SEED;
        else if (adv) s <= s_nxt;
    end
endmodule

module frame_gen_pam4 #(
    parameter int NCH         = 3,
    parameter int SYM_W       = 2,
    parameter int POLY_LENGTH = 7,
    parameter int POLY_TAP    = 6,
    parameter int INV_PATTERN = 0,
    parameter int HEAD_LEN    = 10,
    parameter int PAYLOAD_LEN = 1016,
    parameter int GAP_LEN     = 4
) (
    input  logic             clk,
    input  logic             rst,
    frame_gen_pam4_if.slave  bus
);
    localparam int MAXL0 = (HEAD_LEN > PAYLOAD_LEN) ? HEAD_LEN : PAYLOAD_LEN;
    localparam int MAXL  = (MAXL0 > GAP_LEN) ? MAXL0 : GAP_LEN;
    localparam int CW    = ($clog2(MAXL) < 2) ? 2 : $clog2(MAXL);
    localparam logic [CW-1:0] HEAD_LAST = CW'(HEAD_LEN - 1);
    localparam logic [CW-1:0] PAY_LAST  = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, GAP} state_t;

    state_t                    state, nxt_state, end_state;
    logic [CW-1:0]             sym_cnt, nxt_cnt;
    logic                      arm, cont_r, stop_pend, fe_nxt, take_start;
    logic [NCH-1:0][SYM_W-1:0] lane_sym;

    // A sampled start arms for one cycle so the first header appears one edge later.
    assign take_start = (state == IDLE) && !arm && bus.start;

    always_comb begin
        end_state = (cont_r && !stop_pend && !bus.stop) ? HEAD : IDLE;
        nxt_state = state;
        case (state)
            IDLE:    if (arm) nxt_state = HEAD;
            HEAD:    if (sym_cnt == HEAD_LAST) nxt_state = PAYLOAD;
            PAYLOAD: if (sym_cnt == PAY_LAST) nxt_state = (GAP_LEN > 0) ? GAP : end_state;
            GAP:     if (sym_cnt == GAP_LAST) nxt_state = end_state;
            default: nxt_state = IDLE;
        endcase
        nxt_cnt = (nxt_state != state || nxt_state == IDLE) ? '0 : sym_cnt + 1'b1;
        fe_nxt  = (nxt_state == PAYLOAD) && (nxt_cnt == PAY_LAST);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        frame_gen_pam4_lane #(
            .N    (POLY_LENGTH),
            .T    (POLY_TAP),
            .SYM_W(SYM_W),
            .INV  (INV_PATTERN != 0),
            .SEED ({POLY_LENGTH{1'b1}} ^ POLY_LENGTH'(c))
        ) u_lane (
            .clk (clk),
            .load(rst || nxt_state == IDLE || nxt_state == HEAD),
            .adv (nxt_state == PAYLOAD),
            .sym (lane_sym[c])
        );
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            sym_cnt         <= '0;
            arm             <= 1'b0;
            cont_r          <= 1'b0;
            stop_pend       <= 1'b0;
            bus.data_out    <= '0;
            bus.valid       <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            state   <= nxt_state;
            sym_cnt <= nxt_cnt;
            arm     <= take_start;
            if (take_start) begin
                cont_r    <= bus.continuous;
                stop_pend <= 1'b0;
            end else if (state != IDLE && bus.stop) begin
                stop_pend <= 1'b1;
            end
            bus.busy        <= (nxt_state != IDLE);
            bus.valid       <= (nxt_state == HEAD) || (nxt_state == PAYLOAD);
            bus.frame_start <= (nxt_state == HEAD) && (nxt_cnt == '0);
            bus.frame_end   <= fe_nxt;
            if (fe_nxt) bus.frame_cnt <= bus.frame_cnt + 16'd1;
            case (nxt_state)
                HEAD:    bus.data_out <= nxt_cnt[1] ? '0 : '1;
                PAYLOAD: bus.data_out <= lane_sym;
                default: bus.data_out <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_gen_pam4.sv
// Directed bench for frame_gen_pam4: default PAM4 config, a gapless short-frame
// config and an inverted OOK config, with hand-computed expectations.
module tb_frame_gen_pam4;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    frame_gen_pam4_if #(.NCH(3), .SYM_W(2)) ia ();
    frame_gen_pam4_if #(.NCH(3), .SYM_W(2)) ib ();
    frame_gen_pam4_if #(.NCH(3), .SYM_W(1)) ic ();

    frame_gen_pam4 u_a (.clk(clk), .rst(rst), .bus(ia));
    frame_gen_pam4 #(.HEAD_LEN(4), .PAYLOAD_LEN(8), .GAP_LEN(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
    frame_gen_pam4 #(.SYM_W(1), .INV_PATTERN(1), .PAYLOAD_LEN(16)) u_c (.clk(clk), .rst(rst), .bus(ic));

    logic [5:0] cap  [1016];
    logic [5:0] pay1 [1016];
    bit         bits [3][2032];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {ia.start, ia.continuous, ia.stop} = '0;
        {ib.start, ib.continuous, ib.stop} = '0;
        {ic.start, ic.continuous, ic.stop} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input int d, input logic cont);
        case (d)
            0: begin ia.start = 1'b1; ia.continuous = cont; end
            1: begin ib.start = 1'b1; ib.continuous = cont; end
            default: begin ic.start = 1'b1; ic.continuous = cont; end
        endcase
        @(negedge clk);
        {ia.start, ia.continuous, ib.start, ib.continuous, ic.start, ic.continuous} = '0;
    endtask

    task automatic wait_fs(input int d, output int cyc);
        logic fs;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            fs = (d == 0) ? ia.frame_start : (d == 1) ? ib.frame_start : ic.frame_start;
        end while (!fs && cyc < 50);
    endtask

    // Walks one default frame (header + payload) starting at its frame_start cycle.
    task automatic capture_a(input bit chk_hdr, input int stop_at, output int nv, output int fe_at);
        nv = 0;
        fe_at = -1;
        for (int i = 0; i < 1026; i++) begin
            if (ia.valid) nv++;
            if (ia.frame_end && fe_at < 0) fe_at = i;
            if (chk_hdr && i < 10) chk($sformatf("hdr%0d", i), ia.data_out, ((i & 2) != 0) ? 6'h00 : 6'h3F);
            if (i >= 10) cap[i-10] = ia.data_out;
            ia.stop = (i == stop_at);
            @(negedge clk);
        end
        ia.stop = 1'b0;
    endtask

    task automatic gap_a(output int g);
        g = 0;
        while (ia.busy && g < 50) begin
            if (ia.valid) g += 100;
            g++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat, nv, fe_at, g, errs, found, n;
        logic [7:0] v;

        // Reset state and one single frame.
        do_reset();
        chk("rst_state", {ia.data_out, ia.valid, ia.frame_start, ia.frame_end, ia.busy, ia.frame_cnt}, '0);
        pulse(0, 1'b0);
        wait_fs(0, lat);
        chk("start_lat", lat, 1);
        chk("first_busy", ia.busy, 1);
        capture_a(1'b1, -1, nv, fe_at);
        chk("valid_cnt", nv, 1026);
        chk("fe_pos", fe_at, 1025);
        gap_a(g);
        chk("gap_len", g, 4);
        chk("single_cnt", ia.frame_cnt, 1);
        chk("single_busy", ia.busy, 0);

        for (int p = 0; p < 1016; p++) begin
            pay1[p] = cap[p];
            for (int c = 0; c < 3; c++) begin
                bits[c][2*p]   = cap[p][2*c+1];
                bits[c][2*p+1] = cap[p][2*c];
            end
        end
        chk("ch0_pay", {cap[0][1:0], cap[1][1:0], cap[2][1:0], cap[3][1:0]}, 8'b00_00_00_10);
        chk("ch1_pay", {cap[0][3:2], cap[1][3:2], cap[2][3:2], cap[3][3:2]}, 8'b00_00_01_00);
        chk("ch2_pay", {cap[0][5:4], cap[1][5:4], cap[2][5:4], cap[3][5:4]}, 8'b00_00_11_10);
        errs = 0;
        for (int j = 0; j < 2032 - 127; j++) if (bits[0][j] != bits[0][j+127]) errs++;
        chk("ch0_period127", errs, 0);
        n = 0;
        for (int j = 0; j < 127; j++) n += int'(bits[0][j]);
        chk("ch0_ones", n, 64);
        errs = 0;
        for (int j = 0; j < 2000; j++) if (bits[1][j] != bits[0][j+1]) errs++;
        chk("ch1_shift1", errs, 0);
        found = -1;
        for (int k = 0; k < 127 && found < 0; k++) begin
            errs = 0;
            for (int j = 0; j < 254; j++) if (bits[2][j] != bits[0][j+k]) errs++;
            if (errs == 0) found = k;
        end
        chk("ch2_shifted", found > 0, 1);

        // Continuous run, stop mid-payload of frame 2.
        do_reset();
        pulse(0, 1'b1);
        wait_fs(0, lat);
        capture_a(1'b0, -1, nv, fe_at);
        wait_fs(0, lat);
        chk("cont_gap", lat, 4);
        capture_a(1'b0, 500, nv, fe_at);
        chk("f2_valid_cnt", nv, 1026);
        gap_a(g);
        chk("f2_gap_len", g, 4);
        chk("cont_cnt", ia.frame_cnt, 2);
        errs = 0;
        for (int p = 0; p < 1016; p++) if (cap[p] !== pay1[p]) errs++;
        chk("pay_identical", errs, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n += int'(ia.frame_start) + int'(ia.busy);
        end
        chk("stays_idle", n, 0);

        // Stop on the last gap symbol ends the run at that boundary.
        do_reset();
        pulse(0, 1'b1);
        wait_fs(0, lat);
        capture_a(1'b0, -1, nv, fe_at);
        repeat (3) @(negedge clk);
        ia.stop = 1'b1;
        @(negedge clk);
        ia.stop = 1'b0;
        chk("gapstop_busy", ia.busy, 0);
        chk("gapstop_cnt", ia.frame_cnt, 1);

        // Reset during payload, then restart.
        do_reset();
        pulse(0, 1'b0);
        wait_fs(0, lat);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {ia.data_out, ia.valid, ia.frame_start, ia.frame_end, ia.busy, ia.frame_cnt}, '0);
        pulse(0, 1'b0);
        wait_fs(0, lat);
        chk("restart_lat", lat, 1);
        repeat (10) @(negedge clk);
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v = {v[5:0], ia.data_out[1:0]};
            @(negedge clk);
        end
        chk("restart_pay", v, 8'b00_00_00_10);
        repeat (1030) @(negedge clk);
        rst = 1'b1;
        ia.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ia.start = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n += int'(ia.frame_start) + int'(ia.busy);
        end
        chk("rst_beats_start", n, 0);

        // Gapless frames: period 12, valid never drops, stop on frame_end.
        do_reset();
        pulse(1, 1'b1);
        wait_fs(1, lat);
        nv = 0;
        errs = 0;
        for (int i = 0; i < 36; i++) begin
            if (ib.valid) nv++;
            if (ib.frame_start != ((i % 12) == 0)) errs++;
            if (ib.frame_end != ((i % 12) == 11)) errs++;
            ib.stop = (i == 35);
            @(negedge clk);
        end
        ib.stop = 1'b0;
        chk("b_fs_period", errs, 0);
        chk("b_valid_run", nv, 36);
        chk("b_stop_busy", {ib.busy, ib.valid}, 2'b00);
        chk("b_stop_cnt", ib.frame_cnt, 3);

        // Stop one cycle after frame_end lets one more frame run.
        do_reset();
        pulse(1, 1'b1);
        wait_fs(1, lat);
        repeat (12) @(negedge clk);
        chk("b_f2_start", ib.frame_start, 1);
        ib.stop = 1'b1;
        @(negedge clk);
        ib.stop = 1'b0;
        n = 13;
        while (ib.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b_late_stop_end", n, 24);
        chk("b_late_stop_cnt", ib.frame_cnt, 2);

        // Inverted OOK: header untouched, payload inverted.
        do_reset();
        pulse(2, 1'b0);
        wait_fs(2, lat);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (ic.data_out !== (((i & 2) != 0) ? 3'b000 : 3'b111)) errs++;
            @(negedge clk);
        end
        chk("c_hdr", errs, 0);
        v = '0;
        for (int k = 0; k < 8; k++) begin
            v = {v[6:0], ic.data_out[0]};
            @(negedge clk);
        end
        chk("c_pay", v, 8'b1111_1101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
